user_button_stepper: RTL and testbench
======================================

Name: user_button_stepper

Overview:
- Input-side counterpart to the board LED pattern driver: reads active-low user pushbuttons and turns them into clean, debounced events.
- Maintains a 4-bit step value (0..STEP_MAX) that a downstream LED decoder consumes in place of a free-running counter.
- Button 0 steps up, button 1 steps down, both together clear to 0.
- Sits between raw board pins and the LED pattern logic, in a single clock domain.

Parameters:
- NUM_BTN, 2, number of pushbutton inputs; fixed minimum 2 (btn0 = up, btn1 = down); extra buttons get events only, no step effect.
- SYNC_STAGES, 2, synchronizer flops per button; legal range 2..4.
- DEBOUNCE_CYCLES, 16384, consecutive stable synchronized cycles required to accept a level change; minimum 2.
- STEP_MAX, 12, highest step value; legal range 1..15.
- REPEAT_CYCLES, 8388608, auto-repeat hold/period; used only with the optional feature.

Ports:
- i_clk, input, 1, sole clock.
- i_rst, input, 1, synchronous active-high reset.
- i_btn_l, input, NUM_BTN, raw asynchronous pushbutton pins; active-low (0 = pressed).
- o_btn_level, output, NUM_BTN, debounced level per button; 1 = pressed.
- o_press, output, NUM_BTN, one-cycle pulse when a debounced press is accepted.
- o_release, output, NUM_BTN, one-cycle pulse when a debounced release is accepted.
- o_step, output, 4, current step value, 0..STEP_MAX.
- o_step_valid, output, 1, one-cycle pulse in the cycle o_step takes a new value, including a change to the same value.

Behaviour:
- Interface: one clock (i_clk); reset is synchronous and active-high (i_rst). All outputs are registered.
- Reset values:
  - Synchronizer flops = 1 (released).
  - o_btn_level, o_press, o_release, o_step_valid = 0.
  - o_step = 0.
  - All debounce counters = 0; all FSMs in UP.
  - Asserting i_rst mid-debounce discards the partial count.
- Synchronizer: SYNC_STAGES flops per bit; only the last stage feeds the FSM, inverted to form s_pressed.
- Per-button FSM has four states, each with its own debounce counter:
  - UP: if s_pressed = 1, clear the counter and go to DEB_DOWN.
  - DEB_DOWN: if s_pressed = 0, return to UP (glitch rejected, no event). Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 with s_pressed still 1, go to DOWN and set o_btn_level = 1 and o_press = 1 on that same clock edge.
  - DOWN: if s_pressed = 0, clear the counter and go to DEB_UP.
  - DEB_UP: mirror of DEB_DOWN. On acceptance go to UP, set o_btn_level = 0 and o_release = 1. A bounce back to pressed returns to DOWN with no event.
- Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from the first i_clk edge that samples the pin low to o_press = 1. Release latency is the same.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- Step update, evaluated on press pulses in the same cycle:
  - btn0 and btn1 press in the same cycle: o_step = 0. Highest priority.
  - btn0 press only: o_step + 1. STEP_MAX wraps to 0.
  - btn1 press only: o_step - 1. 0 wraps to STEP_MAX.
  - Press on one button while the other is already held (no pulse on the other): normal single step.
  - o_step_valid pulses in the cycle after the press pulse, aligned with the new o_step.
- o_press and o_release for the same button are never high together. Minimum spacing between them is DEBOUNCE_CYCLES + 1 cycles.

Optional Feature:
- Macro: USER_BUTTON_AUTO_REPEAT_EN.
- Defined:
  - While btn0 or btn1 remains in DOWN, a per-button hold counter runs.
  - After REPEAT_CYCLES in DOWN, an internal repeat pulse fires, then fires again every REPEAT_CYCLES while the button is held.
  - Each repeat pulse steps o_step exactly like a press, with the same wrap and the same o_step_valid pulse. o_press does not pulse on repeats.
  - Leaving DOWN clears the hold counter.
  - If both buttons are held, repeat pulses are suppressed.
- Not defined: no hold counters are built; step changes only on press pulses.

Test Plan:
All runs use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, STEP_MAX=12, REPEAT_CYCLES=20.
1. Clean press: drive i_btn_l[0] = 0 and hold. o_press[0] = 1 for exactly 1 cycle, 6 cycles after the first low sample. o_btn_level[0] = 1. o_step goes 0 -> 1 with o_step_valid pulsed once.
2. Bounce rejection: toggle i_btn_l[0] every 2 cycles for 30 cycles, then hold high. No o_press or o_release; o_step stays 0.
3. Wrap: 12 btn0 presses take o_step to 12; a 13th gives 0. From 0, one btn1 press gives 12.
4. Simultaneous: both pins low on the same cycle with o_step = 7. Both o_press bits pulse together; o_step = 0 and o_step_valid pulses once.
5. Reset mid-operation: assert i_rst for 1 cycle at debounce count 2 during a btn0 press with o_step = 5. The FSM returns to UP and o_step = 0. Holding the pin low afterward gives a fresh press 6 cycles after reset deasserts.
6. With USER_BUTTON_AUTO_REPEAT_EN, hold btn0 for 70 cycles after acceptance: o_step increments at the press and at +20, +40 and +60, for a total of 4 increments. Without the macro: 1 increment.

Source files
------------

// File: rtl/user_button_stepper.sv
// Debounces active-low pushbuttons into level/press/release events and drives a wrapping 0..STEP_MAX step value.
// Optional auto-repeat on held up/down buttons is built when USER_BUTTON_AUTO_REPEAT_EN is defined.

module user_button_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16384
`ifdef USER_BUTTON_AUTO_REPEAT_EN
    ,
    parameter bit HAS_REPEAT      = 1'b0,
    parameter int REPEAT_CYCLES   = 8388608
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic btn_l,
    output logic level,
    output logic press,
    output logic rel
`ifdef USER_BUTTON_AUTO_REPEAT_EN
    ,
    output logic rpt
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {UP, DEB_DOWN, DOWN, DEB_UP} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_pressed;
    logic                   level_nxt, press_nxt, rel_nxt;

    assign s_pressed = ~sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync  <= '1;
            state <= UP;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn_l};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // Counter only advances below CNT_LAST, so it saturates instead of wrapping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            UP: if (s_pressed) begin
                cnt_nxt   = '0;
                state_nxt = DEB_DOWN;
            end
            DEB_DOWN: begin
                if (!s_pressed) begin
                    state_nxt = UP;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DOWN;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DOWN: if (!s_pressed) begin
                cnt_nxt   = '0;
                state_nxt = DEB_UP;
            end
            DEB_UP: begin
                if (s_pressed) begin
                    state_nxt = DOWN;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = UP;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = UP;
        endcase
    end

`ifdef USER_BUTTON_AUTO_REPEAT_EN
    if (HAS_REPEAT) begin : g_rpt
        localparam int HW = $clog2(REPEAT_CYCLES);
        logic [HW-1:0] hold;
        // Hold time restarts whenever the button leaves the settled DOWN state.
        always_ff @(posedge i_clk) begin
            if (i_rst || state != DOWN) begin
                hold <= '0;
                rpt  <= 1'b0;
            end else if (hold == HW'(REPEAT_CYCLES - 1)) begin
                hold <= '0;
                rpt  <= 1'b1;
            end else begin
                hold <= hold + 1'b1;
                rpt  <= 1'b0;
            end
        end
    end else begin : g_no_rpt
        assign rpt = 1'b0;
    end
`endif
endmodule

module user_button_stepper #(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int STEP_MAX        = 12,
    parameter int REPEAT_CYCLES   = 8388608
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn_l,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [3:0]         o_step,
    output logic               o_step_valid
);
    localparam logic [3:0] STEP_LAST = 4'(STEP_MAX);

    logic step_up, step_dn;

`ifdef USER_BUTTON_AUTO_REPEAT_EN
    logic [NUM_BTN-1:0] rpt;
    logic               both_held;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        user_button_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef USER_BUTTON_AUTO_REPEAT_EN
            ,
            .HAS_REPEAT     (i < 2),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
        ) u_lane (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .btn_l(i_btn_l[i]),
            .level(o_btn_level[i]),
            .press(o_press[i]),
            .rel  (o_release[i])
`ifdef USER_BUTTON_AUTO_REPEAT_EN
            ,
            .rpt  (rpt[i])
`endif
        );
    end

`ifdef USER_BUTTON_AUTO_REPEAT_EN
    assign both_held = o_btn_level[0] & o_btn_level[1];
    assign step_up   = o_press[0] | (rpt[0] & ~both_held);
    assign step_dn   = o_press[1] | (rpt[1] & ~both_held);
`else
    assign step_up   = o_press[0];
    assign step_dn   = o_press[1];
`endif

    // Simultaneous presses clear; otherwise a single up/down event steps with wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_step       <= '0;
            o_step_valid <= 1'b0;
        end else begin
            o_step_valid <= 1'b0;
            if (o_press[0] & o_press[1]) begin
                o_step       <= '0;
                o_step_valid <= 1'b1;
            end else if (step_up) begin
                o_step       <= (o_step == STEP_LAST) ? 4'd0 : o_step + 4'd1;
                o_step_valid <= 1'b1;
            end else if (step_dn) begin
                o_step       <= (o_step == 4'd0) ? STEP_LAST : o_step - 4'd1;
                o_step_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_user_button_stepper.sv
// Scoreboard bench for user_button_stepper: directed scenarios plus random button activity vs a run-length reference model.
module tb_user_button_stepper;
    localparam int NB = 2, SS = 2, DC = 4, SM = 12, RC = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_l = '1;
    logic [NB-1:0] level, press, rel;
    logic [3:0]    step;
    logic          step_valid;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_press0 = 0, n_press1 = 0, n_rel = 0, n_sv = 0;

    user_button_stepper #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .STEP_MAX(SM), .REPEAT_CYCLES(RC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_l(btn_l),
        .o_btn_level(level), .o_press(press), .o_release(rel),
        .o_step(step), .o_step_valid(step_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] level;
        logic          sv;
        logic [3:0]    step;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for DC+1 consecutive samples; step arithmetic is modulo SM+1.
    logic sh [NB][SS];
    logic m_level [NB], m_press [NB], m_rel [NB], m_rpt [NB];
    int   m_run [NB], m_hold [NB];
    int   m_step;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < SS; k++) sh[b][k] = 1'b1;
            m_level[b] = 0; m_press[b] = 0; m_rel[b] = 0; m_rpt[b] = 0;
            m_run[b] = 0; m_hold[b] = 0;
        end
        m_step = 0;
    endtask

    task automatic model_step();
        ev_t e;
        bit sv, up, dn, both_held;
        sv = 0;
        both_held = m_level[0] && m_level[1];
        up = m_press[0] || (m_rpt[0] && !both_held);
        dn = m_press[1] || (m_rpt[1] && !both_held);
        if (m_press[0] && m_press[1]) begin m_step = 0; sv = 1; end
        else if (up) begin m_step = (m_step + 1) % (SM + 1); sv = 1; end
        else if (dn) begin m_step = (m_step + SM) % (SM + 1); sv = 1; end
`ifdef USER_BUTTON_AUTO_REPEAT_EN
        for (int b = 0; b < 2; b++) begin
            m_rpt[b] = 0;
            if (m_level[b] && m_run[b] == 0) begin
                m_hold[b]++;
                if (m_hold[b] == RC) begin m_rpt[b] = 1; m_hold[b] = 0; end
            end else m_hold[b] = 0;
        end
`endif
        for (int b = 0; b < NB; b++) begin
            bit s;
            s = !sh[b][SS-1];
            m_press[b] = 0; m_rel[b] = 0;
            if (s != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == DC + 1) begin
                    m_level[b] = s; m_run[b] = 0; m_press[b] = s; m_rel[b] = !s;
                end
            end else m_run[b] = 0;
            for (int k = SS - 1; k > 0; k--) sh[b][k] = sh[b][k-1];
            sh[b][0] = btn_l[b];
        end
        e.cyc = cyc; e.sv = sv; e.step = 4'(m_step);
        for (int b = 0; b < NB; b++) begin
            e.press[b] = m_press[b]; e.rel[b] = m_rel[b]; e.level[b] = m_level[b];
        end
        if (e.press != '0 || e.rel != '0 || sv) exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) model_reset(); else model_step();
    end

    // Monitor: pops one expectation per DUT event, flags expectations the DUT never produced.
    initial forever begin
        ev_t e;
        @(negedge clk);
        if (press[0]) n_press0++;
        if (press[1]) n_press1++;
        if (rel != '0) n_rel++;
        if (step_valid) n_sv++;
        if ((press | rel) != '0 || step_valid) begin
            if (exp_q.size() == 0) check("unexpected_event", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_press", int'(press), int'(e.press));
                check("event_release", int'(rel), int'(e.rel));
                check("event_level", int'(level), int'(e.level));
                check("event_step_valid", int'(step_valid), int'(e.sv));
                check("event_step", int'(step), int'(e.step));
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_event_at_cycle", cyc, -e.cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; btn_l = '1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic tap(int b);
        btn_l[b] = 1'b0; repeat (10) @(negedge clk);
        btn_l[b] = 1'b1; repeat (10) @(negedge clk);
    endtask

    // Counts negedges after the pin change until the press pulse is visible (bounded).
    task automatic wait_press(int b, int max, output int n);
        n = 0;
        while (!press[b] && n < max) begin @(negedge clk); n++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, p1, r0, s0;
        repeat (3) @(negedge clk);
        check("reset_level", int'(level), 0);
        check("reset_press", int'(press | rel), 0);
        check("reset_step", int'(step), 0);
        check("reset_step_valid", int'(step_valid), 0);
        rst = 1'b0;

        // Clean press: pulse 6 cycles after first low sample (7 negedges after the change).
        @(negedge clk); btn_l[0] = 1'b0;
        wait_press(0, 30, n);
        check("press_latency", n, SS + DC + 1);
        @(negedge clk);
        check("press_single_cycle", int'(press[0]), 0);
        check("press_level", int'(level[0]), 1);
        check("press_step", int'(step), 1);
        btn_l[0] = 1'b1; repeat (12) @(negedge clk);
        check("release_level", int'(level[0]), 0);

        // Bounce rejection.
        do_reset();
        p0 = n_press0; r0 = n_rel;
        for (int i = 0; i < 15; i++) begin btn_l[0] = ~btn_l[0]; repeat (2) @(negedge clk); end
        btn_l[0] = 1'b1; repeat (12) @(negedge clk);
        check("bounce_press_count", n_press0 - p0, 0);
        check("bounce_release_count", n_rel - r0, 0);
        check("bounce_step", int'(step), 0);

        // Wrap both directions.
        do_reset();
        for (int i = 0; i < 12; i++) tap(0);
        check("wrap_step_max", int'(step), 12);
        tap(0);
        check("wrap_up_to_zero", int'(step), 0);
        tap(1);
        check("wrap_down_to_max", int'(step), 12);

        // Simultaneous press clears.
        do_reset();
        for (int i = 0; i < 7; i++) tap(0);
        check("simul_pre_step", int'(step), 7);
        s0 = n_sv;
        btn_l = '0;
        wait_press(0, 30, n);
        check("simul_both_press", int'(press), 3);
        repeat (10) @(negedge clk);
        check("simul_step", int'(step), 0);
        check("simul_valid_count", n_sv - s0, 1);
        btn_l = '1; repeat (12) @(negedge clk);

        // Reset in the middle of a debounce.
        do_reset();
        for (int i = 0; i < 5; i++) tap(0);
        check("midrst_pre_step", int'(step), 5);
        btn_l[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_step", int'(step), 0);
        check("midrst_level", int'(level[0]), 0);
        wait_press(0, 30, n);
        check("midrst_fresh_press_latency", n, SS + DC + 1);
        btn_l[0] = 1'b1; repeat (12) @(negedge clk);

        // Long hold: auto-repeat when enabled.
        do_reset();
        btn_l[0] = 1'b0;
        wait_press(0, 30, n);
        s0 = n_sv;
        repeat (70) @(negedge clk);
`ifdef USER_BUTTON_AUTO_REPEAT_EN
        check("hold_increments", n_sv - s0, 4);
        check("hold_step", int'(step), 4);
`else
        check("hold_increments", n_sv - s0, 1);
        check("hold_step", int'(step), 1);
`endif
        btn_l[0] = 1'b1; repeat (12) @(negedge clk);

        // Random activity, including long holds, bounces, overlaps and rare resets.
        begin
            int dur [NB];
            for (int b = 0; b < NB; b++) dur[b] = 1;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 399) == 0);
                for (int b = 0; b < NB; b++) begin
                    dur[b]--;
                    if (dur[b] <= 0) begin
                        btn_l[b] = 1'($urandom_range(0, 1));
                        dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 50))
                                                             : int'($urandom_range(1, 8));
                    end
                end
            end
            @(negedge clk); rst = 1'b0; btn_l = '1;
            repeat (15) @(negedge clk);
        end
        p1 = n_press1;
        check("random_saw_presses", int'(p1 > 0), 1);
        check("final_step", int'(step), m_step);
        check("pending_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
